// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_e          : arbiter FSM states, 3-bit encoding, IDLE = 0
//   DefStartTimeout  : default cycles allowed from Send rising to TxActive rising
//   DefGuardCycles   : default idle cycles between Send falling and the next grant
//   clog2()          : ceiling log2 for sizing index and counter fields
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        RUN     = 3'd2,
        RELEASE = 3'd3,
        GUARD   = 3'd4
    } state_e;

    localparam int DefStartTimeout = 64;
    localparam int DefGuardCycles  = 2;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin selector.
//   req_i   : per-requester pending flags
//   ptr_i   : index with highest priority this arbitration
//   grant_o : one-hot of the selected requester (all zero when nothing pending)
//   idx_o   : binary index of the selected requester
module rr_select
    import uart_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdxW   = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [2*NumReq-1:0] req_dbl;
    logic                found;

    // Doubling the vector turns the wrap-around search into a plain upward scan
    // starting at the pointer.
    assign req_dbl = {req_i, req_i};

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int i = 0; i < 2 * NumReq; i++) begin
            if (!found && (i >= int'(ptr_i)) && req_dbl[i]) begin
                found = 1'b1;
                idx_o = IdxW'(i % NumReq);
            end
        end
        grant_o = found ? (NumReq'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmit path between requesters.
//   Clock, ResetN : system clock, asynchronous active-low reset
//   ReqValid      : per-requester byte pending
//   ReqData       : requester i byte at [i*DataWidth +: DataWidth]
//   ReqAck        : one-cycle capture strobe for the granted requester
//   TxActive      : serializer active flag
//   TxDone        : serializer done flag
//   Send          : level to serializer, high for one frame
//   TxData        : captured byte, stable while Send is high
//   GrantId       : current or last granted requester
//   Busy          : FSM outside IDLE
//   Timeout       : one-cycle pulse on start-timeout abort
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NumReq       = 4,
    parameter  int DataWidth    = 8,
    parameter  int StartTimeout = DefStartTimeout,
    parameter  int GuardCycles  = DefGuardCycles,
    localparam int IdxW         = clog2(NumReq)
) (
    input  logic                        Clock,
    input  logic                        ResetN,
    input  logic [NumReq-1:0]           ReqValid,
    input  logic [NumReq*DataWidth-1:0] ReqData,
    output logic [NumReq-1:0]           ReqAck,
    input  logic                        TxActive,
    input  logic                        TxDone,
    output logic                        Send,
    output logic [DataWidth-1:0]        TxData,
    output logic [IdxW-1:0]             GrantId,
    output logic                        Busy,
    output logic                        Timeout
);

    localparam int TCntW     = clog2(StartTimeout) + 1;
    localparam int GCntW     = clog2(GuardCycles + 1) + 1;
    localparam int GuardLast = (GuardCycles > 0) ? GuardCycles - 1 : 0;
    localparam state_e AfterFrame = (GuardCycles == 0) ? IDLE : GUARD;

    state_e               state_q;
    logic                 send_q;
    logic [DataWidth-1:0] data_q;
    logic [IdxW-1:0]      grant_q;
    logic [NumReq-1:0]    ack_q;
    logic                 timeout_q;
    logic [IdxW-1:0]      ptr_q;
    logic [IdxW-1:0]      ptr_d;
    logic [TCntW-1:0]     tcnt_q;
    logic [GCntW-1:0]     gcnt_q;

    logic [NumReq-1:0]    sel_onehot;
    logic [IdxW-1:0]      sel_idx;

    rr_select #(
        .NumReq (NumReq)
    ) u_rr_select (
        .req_i   (ReqValid),
        .ptr_i   (ptr_q),
        .grant_o (sel_onehot),
        .idx_o   (sel_idx)
    );

    // Priority moves to the requester just after the last grant, whether the
    // frame completed or was aborted.
    assign ptr_d = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            send_q    <= 1'b0;
            data_q    <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            ack_q     <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|ReqValid) begin
                        data_q  <= ReqData[int'(sel_idx)*DataWidth +: DataWidth];
                        grant_q <= sel_idx;
                        ack_q   <= sel_onehot;
                        send_q  <= 1'b1;
                        tcnt_q  <= '0;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (TxActive) begin
                        state_q <= RUN;
                    end else if (tcnt_q == TCntW'(StartTimeout - 1)) begin
                        // Serializer never started: abandon the frame.
                        send_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        ptr_q     <= ptr_d;
                        gcnt_q    <= '0;
                        state_q   <= AfterFrame;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (TxDone && !TxActive) begin
                        send_q  <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    ptr_q   <= ptr_d;
                    gcnt_q  <= '0;
                    state_q <= AfterFrame;
                end
                GUARD: begin
                    if (gcnt_q == GCntW'(GuardLast)) begin
                        state_q <= IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end
                default: begin
                    send_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Send    = send_q;
    assign TxData  = data_q;
    assign GrantId = grant_q;
    assign ReqAck  = ack_q;
    assign Timeout = timeout_q;
    assign Busy    = (state_q != IDLE);

endmodule
